// File: rtl/tree_walk_ctrl_if.sv
// Bundle between the tree walker, its node/feature memories, node_processing and the result consumer.
// Optional walk_cycles signal exists only when TREE_WALK_PERF_EN is defined.
interface tree_walk_ctrl_if #(
    parameter int FEAT_AW = 7
);
    logic               start;
    logic [13:0]        root_addr;
    logic               busy;
    logic               node_rd_en;
    logic [13:0]        node_rd_addr;
    logic [31:0]        node_rd_data;
    logic               feat_rd_en;
    logic [FEAT_AW-1:0] feat_rd_addr;
    logic [8:0]         feat_rd_data;
    logic [8:0]         feature_val;
    logic [13:0]        abs_cur_addr;
    logic [8:0]         cmp_value;
    logic [6:0]         rel_left_child;
    logic [6:0]         rel_right_child;
    logic [13:0]        nxt_node_abs_addr;
    logic               result_valid;
    logic               result_ready;
    logic [7:0]         result_class;
    logic [6:0]         result_depth;
    logic               result_err;
`ifdef TREE_WALK_PERF_EN
    logic [15:0]        walk_cycles;
`endif

    modport master (
        input  start, root_addr, node_rd_data, feat_rd_data, nxt_node_abs_addr, result_ready,
        output busy, node_rd_en, node_rd_addr, feat_rd_en, feat_rd_addr, feature_val,
               abs_cur_addr, cmp_value, rel_left_child, rel_right_child,
               result_valid, result_class, result_depth, result_err
`ifdef TREE_WALK_PERF_EN
        , output walk_cycles
`endif
    );

    modport slave (
        output start, root_addr, node_rd_data, feat_rd_data, nxt_node_abs_addr, result_ready,
        input  busy, node_rd_en, node_rd_addr, feat_rd_en, feat_rd_addr, feature_val,
               abs_cur_addr, cmp_value, rel_left_child, rel_right_child,
               result_valid, result_class, result_depth, result_err
`ifdef TREE_WALK_PERF_EN
        , input walk_cycles
`endif
    );
endinterface

// File: rtl/tree_walk_ctrl.sv
// Walks one decision tree root-to-leaf: 3 cycles for a root leaf plus 5 per internal node; result held until result_ready.
// Define TREE_WALK_PERF_EN to add the saturating walk_cycles counter.
module tree_walk_ctrl #(
    parameter int MAX_DEPTH = 32,
    parameter int FEAT_AW   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    tree_walk_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, NODE_RD, NODE_WAIT, FEAT_RD, FEAT_WAIT, ADV, DONE} state_e;

    localparam logic [6:0] MAX_D = 7'(MAX_DEPTH);

    state_e             state_q, state_d;
    logic [6:0]         depth_q, depth_d;
    logic [13:0]        abs_q, abs_d;
    logic [8:0]         cmp_q, cmp_d;
    logic [6:0]         left_q, left_d, right_q, right_d;
    logic [FEAT_AW-1:0] fidx_q, fidx_d;
    logic [8:0]         fval_q, fval_d;
    logic               nrd_en_q, nrd_en_d, frd_en_q, frd_en_d;
    logic [13:0]        nrd_addr_q, nrd_addr_d;
    logic [FEAT_AW-1:0] frd_addr_q, frd_addr_d;
    logic               busy_q, busy_d;
    logic               rvld_q, rvld_d;
    logic [7:0]         rcls_q, rcls_d;
    logic [6:0]         rdep_q, rdep_d;
    logic               rerr_q, rerr_d;
    logic [6:0]         depth_inc;
    logic               unused_word_bits;

    assign depth_inc        = depth_q + 7'd1;
    assign unused_word_bits = bus.node_rd_data[31];

    always_comb begin
        state_d  = state_q;
        depth_d  = depth_q;
        abs_d    = abs_q;
        cmp_d    = cmp_q;
        left_d   = left_q;
        right_d  = right_q;
        fidx_d   = fidx_q;
        fval_d   = fval_q;
        rvld_d   = 1'b0;
        rcls_d   = rcls_q;
        rdep_d   = rdep_q;
        rerr_d   = rerr_q;
        case (state_q)
            IDLE: if (bus.start) begin
                abs_d   = bus.root_addr;
                depth_d = 7'd0;
                state_d = NODE_RD;
            end
            NODE_RD:   state_d = NODE_WAIT;
            NODE_WAIT: if (bus.node_rd_data[0]) begin
                rcls_d  = bus.node_rd_data[8:1];
                rdep_d  = depth_q;
                rerr_d  = 1'b0;
                state_d = DONE;
            end else begin
                cmp_d   = bus.node_rd_data[23:15];
                left_d  = bus.node_rd_data[14:8];
                right_d = bus.node_rd_data[7:1];
                fidx_d  = bus.node_rd_data[24 +: FEAT_AW];
                state_d = FEAT_RD;
            end
            FEAT_RD:   state_d = FEAT_WAIT;
            FEAT_WAIT: begin
                fval_d  = bus.feat_rd_data;
                state_d = ADV;
            end
            ADV: begin
                // The next address is followed as-is, including any 14-bit wrap.
                abs_d   = bus.nxt_node_abs_addr;
                depth_d = depth_inc;
                if (depth_inc == MAX_D) begin
                    rerr_d  = 1'b1;
                    rcls_d  = 8'd0;
                    rdep_d  = MAX_D;
                    state_d = DONE;
                end else begin
                    state_d = NODE_RD;
                end
            end
            DONE: begin
                // Fields settle on DONE entry; valid follows one cycle later and drops on the handshake edge.
                rvld_d = 1'b1;
                if (rvld_q && bus.result_ready) begin
                    rvld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        nrd_en_d   = (state_d == NODE_RD);
        nrd_addr_d = nrd_en_d ? abs_d : 14'd0;
        frd_en_d   = (state_d == FEAT_RD);
        frd_addr_d = frd_en_d ? fidx_d : '0;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            depth_q    <= '0;
            abs_q      <= '0;
            cmp_q      <= '0;
            left_q     <= '0;
            right_q    <= '0;
            fidx_q     <= '0;
            fval_q     <= '0;
            nrd_en_q   <= 1'b0;
            nrd_addr_q <= '0;
            frd_en_q   <= 1'b0;
            frd_addr_q <= '0;
            busy_q     <= 1'b0;
            rvld_q     <= 1'b0;
            rcls_q     <= '0;
            rdep_q     <= '0;
            rerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            abs_q      <= abs_d;
            cmp_q      <= cmp_d;
            left_q     <= left_d;
            right_q    <= right_d;
            fidx_q     <= fidx_d;
            fval_q     <= fval_d;
            nrd_en_q   <= nrd_en_d;
            nrd_addr_q <= nrd_addr_d;
            frd_en_q   <= frd_en_d;
            frd_addr_q <= frd_addr_d;
            busy_q     <= busy_d;
            rvld_q     <= rvld_d;
            rcls_q     <= rcls_d;
            rdep_q     <= rdep_d;
            rerr_q     <= rerr_d;
        end
    end

`ifdef TREE_WALK_PERF_EN
    logic [15:0] wcyc_q, wcyc_d;

    always_comb begin
        wcyc_d = wcyc_q;
        if (state_q == IDLE) begin
            if (bus.start) wcyc_d = 16'd0;
        end else if (!rvld_q && wcyc_q != 16'hFFFF) begin
            wcyc_d = wcyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcyc_q <= '0;
        else        wcyc_q <= wcyc_d;
    end

    assign bus.walk_cycles = wcyc_q;
`endif

    assign bus.busy            = busy_q;
    assign bus.node_rd_en      = nrd_en_q;
    assign bus.node_rd_addr    = nrd_addr_q;
    assign bus.feat_rd_en      = frd_en_q;
    assign bus.feat_rd_addr    = frd_addr_q;
    assign bus.feature_val     = fval_q;
    assign bus.abs_cur_addr    = abs_q;
    assign bus.cmp_value       = cmp_q;
    assign bus.rel_left_child  = left_q;
    assign bus.rel_right_child = right_q;
    assign bus.result_valid    = rvld_q;
    assign bus.result_class    = rcls_q;
    assign bus.result_depth    = rdep_q;
    assign bus.result_err      = rerr_q;
endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Scoreboard bench for tree_walk_ctrl: two instances (MAX_DEPTH 32 and 4) share one node/feature memory image.
module tb_tree_walk_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tree_walk_ctrl_if #(.FEAT_AW(7)) ifa ();
    tree_walk_ctrl_if #(.FEAT_AW(7)) ifb ();

    tree_walk_ctrl #(.MAX_DEPTH(32), .FEAT_AW(7)) dut  (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
    tree_walk_ctrl #(.MAX_DEPTH(4),  .FEAT_AW(7)) dut4 (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

    logic [31:0] nmem [0:16383];
    logic [8:0]  fmem [0:127];

    always @(posedge clk) begin
        if (ifa.node_rd_en) ifa.node_rd_data <= nmem[ifa.node_rd_addr];
        if (ifa.feat_rd_en) ifa.feat_rd_data <= fmem[ifa.feat_rd_addr];
        if (ifb.node_rd_en) ifb.node_rd_data <= nmem[ifb.node_rd_addr];
        if (ifb.feat_rd_en) ifb.feat_rd_data <= fmem[ifb.feat_rd_addr];
    end

    // Reference node_processing: feature <= cmp goes left, else right; modulo 2^14.
    assign ifa.nxt_node_abs_addr = (ifa.feature_val <= ifa.cmp_value) ?
        ifa.abs_cur_addr + 14'(ifa.rel_left_child) : ifa.abs_cur_addr + 14'(ifa.rel_right_child);
    assign ifb.nxt_node_abs_addr = (ifb.feature_val <= ifb.cmp_value) ?
        ifb.abs_cur_addr + 14'(ifb.rel_left_child) : ifb.abs_cur_addr + 14'(ifb.rel_right_child);

    typedef struct {
        bit          dutb;
        logic [7:0]  cls;
        logic [6:0]  depth;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic pva = 1'b0;
    logic pvb = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] inode(input logic [6:0] fidx, input logic [8:0] cmp,
                                          input logic [6:0] left, input logic [6:0] right);
        return {1'b0, fidx, cmp, left, right, 1'b0};
    endfunction

    function automatic logic [31:0] leaf(input logic [7:0] cls);
        return {23'd0, cls, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_port(input bit which);
        logic       v, r, pv, err;
        logic [7:0] cls;
        logic [6:0] dep;
        v   = which ? ifb.result_valid : ifa.result_valid;
        r   = which ? ifb.result_ready : ifa.result_ready;
        pv  = which ? pvb : pva;
        cls = which ? ifb.result_class : ifa.result_class;
        dep = which ? ifb.result_depth : ifa.result_depth;
        err = which ? ifb.result_err : ifa.result_err;
        if (!v) return;
        if (sbq.size() == 0 || sbq[0].dutb != which) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result dut%0d: got valid=1 class=%0h expected no result", which, cls);
        end else begin
            if (!pv) begin
                chk("latency", cyc - sbq[0].t0, sbq[0].lat);
`ifdef TREE_WALK_PERF_EN
                chk("walk_cycles", which ? ifb.walk_cycles : ifa.walk_cycles, sbq[0].lat);
`endif
            end
            chk("result_class", cls, sbq[0].cls);
            chk("result_depth", dep, sbq[0].depth);
            chk("result_err", err, sbq[0].err);
            if (r) void'(sbq.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_port(1'b0);
            mon_port(1'b1);
            chk("strobe_excl_a", {ifa.node_rd_en & ifa.feat_rd_en,
                                  ifa.result_valid & (ifa.node_rd_en | ifa.feat_rd_en)}, 0);
            chk("strobe_excl_b", {ifb.node_rd_en & ifb.feat_rd_en,
                                  ifb.result_valid & (ifb.node_rd_en | ifb.feat_rd_en)}, 0);
        end
        pva = ifa.result_valid;
        pvb = ifb.result_valid;
    end

    task automatic start_walk(input bit which, input logic [13:0] root, input logic [7:0] cls,
                              input logic [6:0] dep, input logic err, input int lat);
        exp_t e;
        @(posedge clk); #1;
        if (which) begin ifb.start = 1'b1; ifb.root_addr = root; end
        else       begin ifa.start = 1'b1; ifa.root_addr = root; end
        @(posedge clk); #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        e.dutb = which; e.cls = cls; e.depth = dep; e.err = err; e.lat = lat; e.t0 = cyc;
        sbq.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((sbq.size() != 0 || ifa.busy || ifb.busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_done timeout: got %0d pending results expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        ifa.start = 1'b0; ifa.root_addr = '0; ifa.result_ready = 1'b1;
        ifb.start = 1'b0; ifb.root_addr = '0; ifb.result_ready = 1'b1;
        for (int i = 0; i < 16384; i++) nmem[i] = 32'd0;
        for (int i = 0; i < 128; i++)   fmem[i] = 9'd0;
        nmem[14'h0010] = inode(7'd3, 9'd100, 7'd2, 7'd5);
        nmem[14'h0012] = leaf(8'd7);
        nmem[14'h0015] = leaf(8'd9);
        nmem[14'h3FFE] = inode(7'd5, 9'd100, 7'd4, 7'd9);
        nmem[14'h0002] = leaf(8'd3);
        fmem[5] = 9'd10;
        for (int i = 0; i < 5; i++) nmem[14'h0100 + i] = inode(7'd0, 9'd0, 7'd1, 7'd1);
        nmem[14'h0105] = leaf(8'h55);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", ifa.busy, 0);
        chk("rst_node_rd_en", ifa.node_rd_en, 0);
        chk("rst_result_valid", ifa.result_valid, 0);
        chk("rst_abs_cur_addr", ifa.abs_cur_addr, 0);
        rst_n = 1'b1;

        fmem[3] = 9'd50;
        start_walk(1'b0, 14'h0010, 8'd7, 7'd1, 1'b0, 8);
        wait_done(100);

        fmem[3] = 9'd100;
        start_walk(1'b0, 14'h0010, 8'd7, 7'd1, 1'b0, 8);
        wait_done(100);
        fmem[3] = 9'd101;
        start_walk(1'b0, 14'h0010, 8'd9, 7'd1, 1'b0, 8);
        wait_done(100);

        start_walk(1'b0, 14'h3FFE, 8'd3, 7'd1, 1'b0, 8);
        wait_done(100);

        start_walk(1'b1, 14'h0100, 8'd0, 7'd4, 1'b1, 21);
        wait_done(100);
        start_walk(1'b0, 14'h0100, 8'h55, 7'd5, 1'b0, 28);
        wait_done(100);

        // Result held under backpressure; start pulses in DONE and on the handshake edge are ignored.
        fmem[3] = 9'd50;
        ifa.result_ready = 1'b0;
        start_walk(1'b0, 14'h0010, 8'd7, 7'd1, 1'b0, 8);
        begin
            int n = 0;
            while (!ifa.result_valid && n < 50) begin @(posedge clk); #1; n++; end
            chk("s5_valid_seen", ifa.result_valid, 1);
        end
        ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        ifa.result_ready = 1'b1;
        ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        wait_done(100);
        repeat (20) @(posedge clk);
        #1;
        chk("s5_idle_after", ifa.busy, 0);

        // Reset mid-walk during FEAT_WAIT: everything clears and no result follows.
        ifa.start = 1'b1; ifa.root_addr = 14'h0010;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        begin
            int n = 0;
            while (!ifa.feat_rd_en && n < 50) begin @(posedge clk); #1; n++; end
            chk("s5_feat_rd_seen", ifa.feat_rd_en, 1);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", ifa.busy, 0);
        chk("mid_rst_feat_rd_en", ifa.feat_rd_en, 0);
        chk("mid_rst_cmp_value", ifa.cmp_value, 0);
        chk("mid_rst_abs_cur_addr", ifa.abs_cur_addr, 0);
        chk("mid_rst_result_class", ifa.result_class, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_busy", ifa.busy, 0);
        chk("post_rst_pending", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
